// File: rtl/fios_pkg.sv
// Shared types and defaults for the FIOS chain sequencer and its result buffer.
package fios_pkg;

  localparam int FIOS_W = 17;

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/fios_res_buffer.sv
// S-word result buffer: written by core pushes, read back as b words on the next iteration.
// Zero-latency combinational read; writes past S words are dropped and flagged as overflow.
module fios_res_buffer
  import fios_pkg::*;
#(
  parameter int W = FIOS_W,
  parameter int S = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         wr_en,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_en,
  output logic [W-1:0] rd_dat,
  output logic         full,
  output logic         overflow,
  output logic         last_slot,
  output logic         fill_ok
);

  localparam int RD_W = (S > 1) ? $clog2(S) : 1;
  localparam int WR_W = $clog2(S + 1);

  logic [W-1:0]    mem [S];
  logic [WR_W-1:0] wr_ptr;
  logic [RD_W-1:0] rd_ptr;
  logic            accept;

  assign full      = (wr_ptr == WR_W'(S));
  assign accept    = wr_en & ~full;
  assign overflow  = wr_en & full;
  assign last_slot = (wr_ptr == WR_W'(S - 1));
  // Word count as it will stand after this cycle's write, so a push coincident
  // with core done is counted before the check.
  assign fill_ok   = full | (accept & last_slot);
  assign rd_dat    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + WR_W'(1);
      if (rd_en && (rd_ptr != RD_W'(S - 1))) rd_ptr <= rd_ptr + RD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr[RD_W-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/fios_chain_sequencer.sv
// Runs a chain of FIOS multiplications r(k+1) = MM(a, r(k)) per request, feeding b from ext or buffer.
// Start 1 cycle after accept, done 1 cycle after final core done; new requests accepted only in IDLE.
module fios_chain_sequencer
  import fios_pkg::*;
#(
  parameter int W     = FIOS_W,
  parameter int S     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [CNT_W-1:0] req_len_i,
  input  logic [W-1:0]     ext_b_i,
  output logic             ext_b_fetch_o,
  output logic             core_start_o,
  input  logic             core_b_fetch_i,
  output logic [W-1:0]     core_b_o,
  input  logic             core_res_push_i,
  input  logic [W-1:0]     core_res_i,
  input  logic             core_done_i,
  output logic             res_valid_o,
  output logic [W-1:0]     res_o,
  output logic             res_last_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] iter_o,
  output logic             err_o
);

  state_t           state;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] iter;
  logic             err;
  logic             running;
  logic             final_iter;
  logic             final_capture;
  logic             buf_full;
  logic             buf_overflow;
  logic             buf_last_slot;
  logic             buf_fill_ok;
  logic [W-1:0]     buf_rd;

  assign running       = (state == RUN);
  assign final_iter    = (iter == len - CNT_W'(1));
  assign final_capture = running & final_iter & core_res_push_i & ~buf_full;

  fios_res_buffer #(
    .W (W),
    .S (S)
  ) u_res_buffer (
    .clk       (clock_i),
    .rst_n     (reset_ni),
    .clear     (state == START),
    .wr_en     (running & core_res_push_i),
    .wr_dat    (core_res_i),
    .rd_en     (running & core_b_fetch_i),
    .rd_dat    (buf_rd),
    .full      (buf_full),
    .overflow  (buf_overflow),
    .last_slot (buf_last_slot),
    .fill_ok   (buf_fill_ok)
  );

  assign req_ready_o  = (state == IDLE);
  assign busy_o       = (state != IDLE);
  assign core_start_o = (state == START);
  assign done_o       = (state == DONE);
  assign iter_o       = iter;
  assign err_o        = err;

  // Iteration 0 consumes the external stream; later iterations replay the previous result.
  always_comb begin
    core_b_o      = '0;
    ext_b_fetch_o = 1'b0;
    if (state != IDLE) begin
      if (iter == '0) begin
        core_b_o      = ext_b_i;
        ext_b_fetch_o = running & core_b_fetch_i;
      end else begin
        core_b_o = buf_rd;
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state       <= IDLE;
      len         <= '0;
      iter        <= '0;
      err         <= 1'b0;
      res_valid_o <= 1'b0;
      res_o       <= '0;
      res_last_o  <= 1'b0;
    end else begin
      res_valid_o <= final_capture;
      res_last_o  <= final_capture & buf_last_slot;
      if (final_capture) res_o <= core_res_i;
      if (buf_overflow || (running && core_done_i && !buf_fill_ok)) err <= 1'b1;

      case (state)
        IDLE: begin
          if (req_valid_i) begin
            len   <= (req_len_i == '0) ? CNT_W'(1) : req_len_i;
            iter  <= '0;
            err   <= 1'b0;
            state <= START;
          end
        end
        START: state <= RUN;
        RUN: begin
          if (core_done_i) begin
            if (final_iter) begin
              state <= DONE;
            end else begin
              iter  <= iter + CNT_W'(1);
              state <= START;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fios_chain_sequencer.sv
// Directed bench for fios_chain_sequencer: table of chain jobs plus reset-abort sequence.
module tb_fios_chain_sequencer;

  localparam int W     = 17;
  localparam int S     = 8;
  localparam int CNT_W = 8;

  logic             clock_i = 1'b0;
  logic             reset_ni = 1'b0;
  logic             req_valid_i = 1'b0;
  logic [CNT_W-1:0] req_len_i = '0;
  logic [W-1:0]     ext_b_i = '0;
  logic             core_b_fetch_i = 1'b0;
  logic             core_res_push_i = 1'b0;
  logic [W-1:0]     core_res_i = '0;
  logic             core_done_i = 1'b0;
  logic             req_ready_o, ext_b_fetch_o, core_start_o, res_valid_o, res_last_o;
  logic             busy_o, done_o, err_o;
  logic [W-1:0]     core_b_o, res_o;
  logic [CNT_W-1:0] iter_o;

  fios_chain_sequencer #(.W(W), .S(S), .CNT_W(CNT_W)) dut (
    .clock_i         (clock_i),
    .reset_ni        (reset_ni),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_len_i       (req_len_i),
    .ext_b_i         (ext_b_i),
    .ext_b_fetch_o   (ext_b_fetch_o),
    .core_start_o    (core_start_o),
    .core_b_fetch_i  (core_b_fetch_i),
    .core_b_o        (core_b_o),
    .core_res_push_i (core_res_push_i),
    .core_res_i      (core_res_i),
    .core_done_i     (core_done_i),
    .res_valid_o     (res_valid_o),
    .res_o           (res_o),
    .res_last_o      (res_last_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .iter_o          (iter_o),
    .err_o           (err_o)
  );

  always #5 clock_i = ~clock_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rval(input int it, input int i);
    return W'(32'h0A000 + it * 256 + i);
  endfunction

  // Observation counters, all sampled on the falling edge.
  int cyc = 0;
  int n_start, n_done, n_res, n_ext, ext_bad, iter_bad, gap_bad, last_pos, fidx;
  int first_start, acc_cyc, core_done_cyc, done_cyc, rdy_rise;
  logic rdy_prev = 1'b1;
  logic [W-1:0] b0 [S];
  logic [W-1:0] b1 [S];
  logic [W-1:0] resw [S+2];

  always @(posedge clock_i) cyc++;

  always @(negedge clock_i) begin
    if (req_valid_i && req_ready_o) acc_cyc = cyc;
    if (core_start_o) begin
      if (n_start == 0) first_start = cyc;
      else if (cyc != core_done_cyc + 1) gap_bad++;
      if (int'(iter_o) != n_start) iter_bad++;
      n_start++;
      fidx = 0;
    end
    if (core_b_fetch_i && busy_o) begin
      if (fidx < S) begin
        if (iter_o == 0) b0[fidx] = core_b_o;
        else if (iter_o == 1) b1[fidx] = core_b_o;
      end
      fidx++;
    end
    if (ext_b_fetch_o) begin
      n_ext++;
      if (iter_o != 0) ext_bad++;
    end
    if (core_done_i && busy_o) core_done_cyc = cyc;
    if (done_o) begin
      n_done++;
      done_cyc = cyc;
    end
    if (res_valid_o) begin
      if (n_res < S + 2) resw[n_res] = res_o;
      n_res++;
      if (res_last_o) last_pos = n_res;
    end
    if (req_ready_o && !rdy_prev) rdy_rise = cyc;
    rdy_prev = req_ready_o;
  end

  task automatic clear_mon();
    n_start = 0; n_done = 0; n_res = 0; n_ext = 0; ext_bad = 0; iter_bad = 0;
    gap_bad = 0; last_pos = 0; fidx = 0; first_start = -1; acc_cyc = -10;
    core_done_cyc = -10; done_cyc = -10; rdy_rise = -10;
    for (int i = 0; i < S; i++) begin
      b0[i] = '0;
      b1[i] = '0;
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  // Core model: called in the START cycle; fetches S b words, pushes npush results, then done.
  task automatic core_iter(input int it, input int npush, input bit coinc);
    tick();
    for (int i = 0; i < S; i++) begin
      core_b_fetch_i = 1'b1;
      ext_b_i = W'(i + 1);
      tick();
    end
    core_b_fetch_i = 1'b0;
    ext_b_i = '0;
    for (int i = 0; i < npush; i++) begin
      core_res_push_i = 1'b1;
      core_res_i = rval(it, i);
      core_done_i = coinc && (i == npush - 1);
      tick();
    end
    core_res_push_i = 1'b0;
    if (!(coinc && npush > 0)) begin
      core_done_i = 1'b1;
      tick();
    end
    core_done_i = 1'b0;
  endtask

  task automatic run_job(input int len_req, input int bad_it, input int bad_n, input bit coinc,
                         input int exp_res, input int exp_last, input bit exp_err);
    int eff, n, bmis0, bmis1, rmis;
    eff = (len_req == 0) ? 1 : len_req;
    clear_mon();
    n = 0;
    while (!req_ready_o && n < 50) begin tick(); n++; end
    req_valid_i = 1'b1;
    req_len_i = CNT_W'(len_req);
    tick();
    req_valid_i = 1'b0;
    chk("busy_after_accept", busy_o, 1);
    chk("err_cleared_on_accept", err_o, 0);
    for (int it = 0; it < eff; it++) begin
      n = 0;
      while (!core_start_o && n < 50) begin tick(); n++; end
      chk("start_seen", core_start_o, 1);
      if (!core_start_o) break;
      core_iter(it, (it == bad_it) ? bad_n : S, coinc);
    end
    n = 0;
    while (!req_ready_o && n < 50) begin tick(); n++; end
    chk("ready_after_job", req_ready_o, 1);
    tick();

    bmis0 = 0; bmis1 = 0; rmis = 0;
    for (int i = 0; i < S; i++) begin
      if (b0[i] !== W'(i + 1)) bmis0++;
      if (b1[i] !== rval(0, i)) bmis1++;
    end
    for (int i = 0; i < n_res && i < S + 2; i++)
      if (resw[i] !== rval(eff - 1, i)) rmis++;

    chk("start_count", n_start, eff);
    chk("first_start_cycle", first_start, acc_cyc + 1);
    chk("restart_gap_bad", gap_bad, 0);
    chk("iter_sequence_bad", iter_bad, 0);
    chk("done_count", n_done, 1);
    chk("done_cycle", done_cyc, core_done_cyc + 1);
    chk("ready_cycle", rdy_rise, done_cyc + 1);
    chk("ext_fetch_count", n_ext, S);
    chk("ext_fetch_late_iter", ext_bad, 0);
    chk("iter0_b_mismatches", bmis0, 0);
    if (eff >= 2) chk("iter1_b_chain_mismatches", bmis1, 0);
    chk("res_valid_count", n_res, exp_res);
    chk("res_last_position", last_pos, exp_last);
    chk("res_word_mismatches", rmis, 0);
    chk("err_sticky", err_o, exp_err);
  endtask

  typedef struct {
    int len;
    int bad_it;
    int bad_n;
    bit coinc;
    int exp_res;
    int exp_last;
    bit exp_err;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{len: 1, bad_it: -1, bad_n: 0, coinc: 0, exp_res: 8, exp_last: 8, exp_err: 0};
    vecs[1] = '{len: 3, bad_it: -1, bad_n: 0, coinc: 0, exp_res: 8, exp_last: 8, exp_err: 0};
    vecs[2] = '{len: 0, bad_it: -1, bad_n: 0, coinc: 0, exp_res: 8, exp_last: 8, exp_err: 0};
    vecs[3] = '{len: 1, bad_it: 0,  bad_n: 9, coinc: 0, exp_res: 8, exp_last: 8, exp_err: 1};
    vecs[4] = '{len: 1, bad_it: 0,  bad_n: 7, coinc: 0, exp_res: 7, exp_last: 0, exp_err: 1};
    vecs[5] = '{len: 2, bad_it: -1, bad_n: 0, coinc: 1, exp_res: 8, exp_last: 8, exp_err: 0};
    vecs[6] = '{len: 3, bad_it: 1,  bad_n: 7, coinc: 0, exp_res: 8, exp_last: 8, exp_err: 1};

    clear_mon();
    #2;
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_core_start", core_start_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_res_valid", res_valid_o, 0);
    chk("rst_res", res_o, 0);
    chk("rst_res_last", res_last_o, 0);
    chk("rst_iter", iter_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_ext_fetch", ext_b_fetch_o, 0);
    chk("rst_core_b", core_b_o, 0);
    repeat (2) @(posedge clock_i);
    #1 reset_ni = 1'b1;
    tick();

    for (int v = 0; v < 7; v++)
      run_job(vecs[v].len, vecs[v].bad_it, vecs[v].bad_n, vecs[v].coinc,
              vecs[v].exp_res, vecs[v].exp_last, vecs[v].exp_err);

    // Abort a len=3 job in the middle of iteration 1.
    clear_mon();
    req_valid_i = 1'b1;
    req_len_i = CNT_W'(3);
    tick();
    req_valid_i = 1'b0;
    core_iter(0, S, 1'b0);
    tick();
    core_b_fetch_i = 1'b1;
    tick();
    tick();
    chk("abort_iter_before_reset", iter_o, 1);
    reset_ni = 1'b0;
    #1;
    chk("abort_busy", busy_o, 0);
    chk("abort_req_ready", req_ready_o, 1);
    chk("abort_iter", iter_o, 0);
    chk("abort_core_start", core_start_o, 0);
    chk("abort_core_b", core_b_o, 0);
    chk("abort_ext_fetch", ext_b_fetch_o, 0);
    chk("abort_res_valid", res_valid_o, 0);
    chk("abort_done", done_o, 0);
    chk("abort_err", err_o, 0);
    core_b_fetch_i = 1'b0;
    repeat (2) tick();
    reset_ni = 1'b1;
    repeat (4) tick();
    chk("abort_no_done", n_done, 0);
    run_job(1, -1, 0, 1'b0, 8, 8, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
